// File: rtl/branch_predictor_pkg.sv
// Shared LC-3b types for the branch predictor: word/op types, BTB geometry and entry layout.
// Counter width follows BP_TWO_BIT_COUNTER_EN (2-bit saturating when defined, 1-bit last-outcome otherwise).
package lc3b_types;

  localparam int INDEX_BITS = 4;
  localparam int PC_WIDTH   = 16;
  localparam int ENTRIES    = 1 << INDEX_BITS;
  localparam int TAG_W      = PC_WIDTH - INDEX_BITS - 1;

`ifdef BP_TWO_BIT_COUNTER_EN
  localparam int CTR_W = 2;
  localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;
`else
  localparam int CTR_W = 1;
  localparam logic [CTR_W-1:0] CTR_RESET = 1'b0;
`endif

  typedef logic [PC_WIDTH-1:0] lc3b_word;
  typedef logic [3:0]          cf_op_t;

  localparam cf_op_t CF_NONE   = 4'd0;
  localparam cf_op_t CF_BRANCH = 4'd1;
  localparam cf_op_t CF_JMP    = 4'd2;
  localparam cf_op_t CF_JSR    = 4'd3;
  localparam cf_op_t CF_TRAP   = 4'd4;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    lc3b_word         target;
    logic             is_branch;
    logic [CTR_W-1:0] counter;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and commit training bundle. There is no handshake: update is a single-cycle
// strobe (one training event per cycle it is high) and the lookup answers pc combinationally.
interface branch_predictor_if;
  import lc3b_types::*;

  logic     update;
  logic     update_is_branch;
  lc3b_word update_pc;
  logic     update_taken;
  lc3b_word update_target;
  cf_op_t   update_op;
  lc3b_word pc;
  logic     is_control_flow;
  logic     should_take;
  lc3b_word address;

  modport master (
    output update, update_is_branch, update_pc, update_taken, update_target, update_op, pc,
    input  is_control_flow, should_take, address
  );

  modport slave (
    input  update, update_is_branch, update_pc, update_taken, update_target, update_op, pc,
    output is_control_flow, should_take, address
  );

endinterface

// File: rtl/branch_predictor_counter.sv
// bp_counter: next direction-counter value for a BTB write.
// BP_TWO_BIT_COUNTER_EN selects 2-bit saturating; otherwise 1-bit last outcome.
module bp_counter
  import lc3b_types::*;
(
  input  logic [CTR_W-1:0] cur,
  input  logic             hit,
  input  logic             is_branch,
  input  logic             taken,
  output logic [CTR_W-1:0] next
);

`ifdef BP_TWO_BIT_COUNTER_EN
  always_comb begin
    next = 2'b11;
    if (is_branch) begin
      // a fresh allocation starts weakly biased toward the observed direction
      if (!hit)
        next = taken ? 2'b10 : 2'b01;
      else if (taken)
        next = (cur == 2'b11) ? cur : cur + 2'd1;
      else
        next = (cur == 2'b00) ? cur : cur - 2'd1;
    end
  end
`else
  logic unused_state;
  assign unused_state = ^{cur, hit};

  always_comb begin
    next = is_branch ? taken : 1'b1;
  end
`endif

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters; combinational lookup, commit-time training.
// Counter flavour selected by BP_TWO_BIT_COUNTER_EN (see lc3b_types).
module branch_predictor
  import lc3b_types::*;
(
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bus
);

  btb_entry_t entries [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      up_tag;
  btb_entry_t            lk_entry;
  btb_entry_t            up_entry;
  btb_entry_t            new_entry;
  logic                  lk_hit;
  logic                  up_hit;
  logic                  write_en;
  logic [CTR_W-1:0]      next_counter;
  logic                  unused_pc_lsb;

  // bit 0 never selects an instruction, so it plays no part in index or tag
  assign unused_pc_lsb = bus.pc[0] ^ bus.update_pc[0];

  assign lk_idx   = bus.pc[INDEX_BITS:1];
  assign lk_tag   = bus.pc[PC_WIDTH-1:INDEX_BITS+1];
  assign lk_entry = entries[lk_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);

  assign bus.is_control_flow = lk_hit;
  assign bus.should_take     = lk_hit && (lk_entry.is_branch ? lk_entry.counter[CTR_W-1] : 1'b1);
  assign bus.address         = lk_hit ? lk_entry.target : '0;

  assign up_idx   = bus.update_pc[INDEX_BITS:1];
  assign up_tag   = bus.update_pc[PC_WIDTH-1:INDEX_BITS+1];
  assign up_entry = entries[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);
  assign write_en = bus.update && (bus.update_op != CF_NONE);

  bp_counter u_counter (
    .cur       (up_entry.counter),
    .hit       (up_hit),
    .is_branch (bus.update_is_branch),
    .taken     (bus.update_taken),
    .next      (next_counter)
  );

  always_comb begin
    new_entry           = up_entry;
    new_entry.valid     = 1'b1;
    new_entry.tag       = up_tag;
    new_entry.target    = bus.update_target;
    new_entry.is_branch = bus.update_is_branch;
    new_entry.counter   = next_counter;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i] <= '{valid: 1'b0, tag: '0, target: '0, is_branch: 1'b0, counter: CTR_RESET};
      end
    end else if (write_en) begin
      entries[up_idx] <= new_entry;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then random training/lookup
// against an array-based reference model; honours BP_TWO_BIT_COUNTER_EN like the design.
module tb_branch_predictor;
  import lc3b_types::*;

  logic clk;
  logic reset;
  branch_predictor_if bus ();

  branch_predictor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: one record per BTB slot, counter kept as a plain integer
  bit m_valid [16];
  int m_tag   [16];
  int m_tgt   [16];
  bit m_isbr  [16];
  int m_ctr   [16];

`ifdef BP_TWO_BIT_COUNTER_EN
  localparam bit TWO_BIT = 1'b1;
`else
  localparam bit TWO_BIT = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot(input int p);
    return (p / 2) % 16;
  endfunction

  function automatic int tag_of(input int p);
    return p / 32;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_isbr[i] = 1'b0;
      m_ctr[i]   = TWO_BIT ? 1 : 0;
    end
  endtask

  task automatic model_lookup(input int p, output bit hit, output bit take, output int addr);
    int s;
    s    = slot(p);
    hit  = m_valid[s] && (m_tag[s] == tag_of(p));
    take = 1'b0;
    addr = 0;
    if (hit) begin
      addr = m_tgt[s];
      if (!m_isbr[s])   take = 1'b1;
      else if (TWO_BIT) take = (m_ctr[s] >= 2);
      else              take = (m_ctr[s] == 1);
    end
  endtask

  task automatic model_train(input int op, input int upc, input bit tk, input int tgt);
    int s;
    bit isbr;
    bit hit;
    if (op == 0) return;
    s    = slot(upc);
    isbr = (op == 1);
    hit  = m_valid[s] && (m_tag[s] == tag_of(upc));
    if (TWO_BIT) begin
      if (!isbr)     m_ctr[s] = 3;
      else if (!hit) m_ctr[s] = tk ? 2 : 1;
      else if (tk)   m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
      else           m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
    end else begin
      m_ctr[s] = isbr ? int'(tk) : 1;
    end
    m_valid[s] = 1'b1; m_tag[s] = tag_of(upc); m_tgt[s] = tgt; m_isbr[s] = isbr;
  endtask

  task automatic check_outputs(input string tag);
    bit hit;
    bit take;
    int addr;
    model_lookup(int'(bus.pc), hit, take, addr);
    check({tag, ".hit"},  32'(bus.is_control_flow), 32'(hit));
    check({tag, ".take"}, 32'(bus.should_take),     32'(take));
    check({tag, ".addr"}, 32'(bus.address),         32'(addr));
  endtask

  // one clock: drive update + lookup, check lookup against pre-edge state, then commit the model
  task automatic cycle(input logic u, input logic [3:0] op, input logic [15:0] upc,
                       input logic tk, input logic [15:0] tgt, input logic [15:0] lpc,
                       input string tag);
    bus.update           = u;
    bus.update_op        = op;
    bus.update_is_branch = (op == CF_BRANCH);
    bus.update_pc        = upc;
    bus.update_taken     = tk;
    bus.update_target    = tgt;
    bus.pc               = lpc;
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    if (u) model_train(int'(op), int'(upc), tk, int'(tgt));
    #1;
    bus.update = 1'b0;
  endtask

  task automatic peek(input logic [15:0] lpc, input string tag);
    bus.pc = lpc;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [15:0] rpc;
    logic [15:0] rupc;
    reset = 1'b1;
    bus.update = 1'b0; bus.update_op = CF_NONE; bus.update_is_branch = 1'b0;
    bus.update_pc = '0; bus.update_taken = 1'b0; bus.update_target = '0; bus.pc = 16'h0040;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    peek(16'h0040, "reset");
    check("reset.hit_const", 32'(bus.is_control_flow), 32'd0);
    check("reset.addr_const", 32'(bus.address), 32'd0);

    cycle(1'b1, CF_BRANCH, 16'h0040, 1'b1, 16'h0100, 16'h0040, "train_first");
    peek(16'h0040, "after_taken");
    check("after_taken.hit_const", 32'(bus.is_control_flow), 32'd1);
    check("after_taken.take_const", 32'(bus.should_take), 32'd1);
    check("after_taken.addr_const", 32'(bus.address), 32'h0100);

    cycle(1'b1, CF_BRANCH, 16'h0040, 1'b0, 16'h0100, 16'h0041, "nt1");
    peek(16'h0040, "after_nt1");
    check("after_nt1.take_const", 32'(bus.should_take), 32'd0);
    cycle(1'b1, CF_BRANCH, 16'h0040, 1'b0, 16'h0100, 16'h0040, "nt2");
    cycle(1'b1, CF_BRANCH, 16'h0040, 1'b1, 16'h0100, 16'h0040, "tk_after_nt");
    peek(16'h0040, "after_tk_after_nt");

    cycle(1'b0, CF_BRANCH, 16'h0040, 1'b1, 16'h0F00, 16'h0040, "strobe_low");
    cycle(1'b1, CF_NONE,   16'h0040, 1'b1, 16'h0F00, 16'h0040, "op_none");
    peek(16'h0040, "after_none");

    cycle(1'b1, CF_JSR, 16'h0060, 1'b0, 16'h2000, 16'h0060, "jsr");
    peek(16'h0060, "after_jsr");
    check("jsr.take_const", 32'(bus.should_take), 32'd1);
    check("jsr.addr_const", 32'(bus.address), 32'h2000);
    peek(16'h0040, "alias");
    check("alias.hit_const", 32'(bus.is_control_flow), 32'd0);

    cycle(1'b1, CF_BRANCH, 16'h0040, 1'b1, 16'h0100, 16'h0040, "retrain");
    cycle(1'b1, CF_JMP,    16'h0040, 1'b0, 16'h0300, 16'h0040, "same_cycle");
    peek(16'h0040, "same_cycle_next");
    check("same_cycle_next.addr_const", 32'(bus.address), 32'h0300);

    // asynchronous clear: outputs must drop before any clock edge
    reset = 1'b1;
    #1;
    check("async_reset.hit", 32'(bus.is_control_flow), 32'd0);
    check("async_reset.addr", 32'(bus.address), 32'd0);
    model_reset();
    bus.update = 1'b1; bus.update_op = CF_TRAP; bus.update_pc = 16'h0040;
    bus.update_target = 16'h0500; bus.update_is_branch = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.update = 1'b0;
    peek(16'h0040, "update_under_reset");

    for (int n = 0; n < 400; n++) begin
      rupc = 16'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
      rpc  = 16'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 4)), rupc,
            1'($urandom_range(0, 1)), 16'($urandom), rpc, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
